pulse_oscillator: RTL and testbench

- Phase-accumulator oscillator that generates the `OSCILLATOR::oscillator_state_t` state and `CONFIG::long_percent_t` phase consumed by the pulse waveform shaper.
- Advances once per audio sample strobe and splits each period into FRONT and BACK segments at a programmable duty threshold.
- Latches new pitch and duty only at period wrap, so parameter changes are glitch-free.
- Sits between the voice/MIDI control logic and the waveform shapers, one instance per voice.

---
 rtl/pulse_oscillator_pkg.sv | 27 ++
 rtl/pulse_oscillator_acc.sv | 30 +++
 rtl/pulse_oscillator.sv | 111 +++++++++++
 tb/tb_pulse_oscillator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_oscillator_pkg.sv
// Shared types for the pulse oscillator: phase fraction width, segment
// states, control FSM encoding and the accumulator-to-phase helper.
package pulse_oscillator_pkg;

  localparam int LONG_PERCENT_WIDTH = 16;
  localparam int MAX_ACC_WIDTH      = 64;

  typedef logic [LONG_PERCENT_WIDTH-1:0] long_percent_t;

  typedef enum logic {
    FRONT = 1'b0,
    BACK  = 1'b1
  } oscillator_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } osc_fsm_t;

  // Top LONG_PERCENT_WIDTH bits of an accumulator of width acc_width,
  // passed zero-extended so one function serves every accumulator size.
  function automatic long_percent_t phase_of(input logic [MAX_ACC_WIDTH-1:0] acc,
                                             input int acc_width);
    return long_percent_t'(acc >> (acc_width - LONG_PERCENT_WIDTH));
  endfunction

endpackage

// File: rtl/pulse_oscillator_acc.sv
// Phase accumulator register with modulo-2^ACC_WIDTH add and carry-out.
// Exposes the next value combinationally so the owner can compare it this cycle.
module phase_accumulator #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 advance_i,
  input  logic [ACC_WIDTH-1:0] inc_i,
  output logic [ACC_WIDTH-1:0] acc_next_o,
  output logic                 carry_o
);

  logic [ACC_WIDTH-1:0] acc_q;

  assign {carry_o, acc_next_o} = {1'b0, acc_q} + {1'b0, inc_i};

  // Clear outranks advance so a restart coinciding with a tick lands on 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (advance_i) begin
      acc_q <= acc_next_o;
    end
  end

endmodule

// File: rtl/pulse_oscillator.sv
// Per-voice pulse oscillator: advances a phase accumulator on each sample tick,
// reports FRONT/BACK segment against a duty threshold latched at period wrap.
module pulse_oscillator
  import pulse_oscillator_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 enable,
  input  logic                 restart,
  input  logic [ACC_WIDTH-1:0] increment,
  input  long_percent_t        duty,
  output oscillator_state_t    state,
  output long_percent_t        phase,
  output logic                 valid,
  output logic                 wrap
);

  osc_fsm_t             fsm_q;
  logic [ACC_WIDTH-1:0] inc_q;
  long_percent_t        duty_q;
  oscillator_state_t    state_q;
  long_percent_t        phase_q;
  logic                 valid_q;
  logic                 wrap_q;

  logic [ACC_WIDTH-1:0] acc_next;
  logic                 carry;
  logic                 acc_clear;
  logic                 acc_advance;
  long_percent_t        next_phase;
  long_percent_t        duty_eff;

  assign acc_clear   = (fsm_q == IDLE) || !enable || restart;
  assign acc_advance = (fsm_q == RUN) && enable && !restart && sample_tick;

  phase_accumulator #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (acc_clear),
    .advance_i  (acc_advance),
    .inc_i      (inc_q),
    .acc_next_o (acc_next),
    .carry_o    (carry)
  );

  // On a wrap the freshly latched duty already governs this tick's compare.
  assign next_phase = phase_of(64'(acc_next), ACC_WIDTH);
  assign duty_eff   = carry ? duty : duty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      inc_q   <= '0;
      duty_q  <= '0;
      state_q <= FRONT;
      phase_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (enable) begin
            inc_q  <= increment;
            duty_q <= duty;
            fsm_q  <= RUN;
            if (restart) begin
              valid_q <= 1'b1;
              phase_q <= '0;
              state_q <= (duty != '0) ? FRONT : BACK;
            end
          end
        end
        RUN: begin
          if (!enable) begin
            fsm_q   <= IDLE;
            state_q <= FRONT;
            phase_q <= '0;
          end else if (restart) begin
            inc_q   <= increment;
            duty_q  <= duty;
            valid_q <= 1'b1;
            phase_q <= '0;
            state_q <= (duty != '0) ? FRONT : BACK;
          end else if (sample_tick) begin
            valid_q <= 1'b1;
            wrap_q  <= carry;
            phase_q <= next_phase;
            state_q <= (next_phase < duty_eff) ? FRONT : BACK;
            if (carry) begin
              inc_q  <= increment;
              duty_q <= duty;
            end
          end
        end
      endcase
    end
  end

  assign state = state_q;
  assign phase = phase_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_pulse_oscillator.sv
// Directed-vector bench for pulse_oscillator with hand-computed expectations.
module tb_pulse_oscillator;
  import pulse_oscillator_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_tick = 1'b0;
  logic              enable = 1'b0;
  logic              restart = 1'b0;
  logic [31:0]       increment = '0;
  long_percent_t     duty = '0;
  oscillator_state_t state;
  long_percent_t     phase;
  logic              valid;
  logic              wrap;

  int checks = 0;
  int errors = 0;

  pulse_oscillator #(.ACC_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .enable      (enable),
    .restart     (restart),
    .increment   (increment),
    .duty        (duty),
    .state       (state),
    .phase       (phase),
    .valid       (valid),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  // {valid, wrap, state(0=FRONT,1=BACK), phase}
  function automatic logic [18:0] obs();
    return {valid, wrap, (state == BACK), phase};
  endfunction

  function automatic logic [18:0] ev(input logic v, input logic w, input logic s,
                                     input logic [15:0] p);
    return {v, w, s, p};
  endfunction

  // Called at a negedge: apply inputs, let one posedge pass, return at next negedge.
  task automatic step(input logic t, input logic r, input logic e);
    sample_tick = t;
    restart     = r;
    enable      = e;
    @(negedge clk);
    sample_tick = 1'b0;
    restart     = 1'b0;
  endtask

  task automatic start(input logic [31:0] inc, input logic [15:0] d);
    step(1'b0, 1'b0, 1'b0);
    increment = inc;
    duty      = d;
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    $display("reset: obs=%h", obs());
    if (obs() !== 19'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs(), 19'h0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_square();
    logic [18:0] exp_v [4];
    exp_v = '{ev(1,0,0,16'h4000), ev(1,0,1,16'h8000), ev(1,0,1,16'hC000), ev(1,1,0,16'h0000)};
    start(32'h4000_0000, 16'h8000);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1);
      checks++;
      $display("square[%0d]: obs=%h", i, obs());
      if (obs() !== exp_v[i % 4]) begin
        errors++;
        $display("FAIL square[%0d]: got %h expected %h", i, obs(), exp_v[i % 4]);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    $display("square_hold: obs=%h", obs());
    if (obs() !== ev(0,0,0,16'h0000)) begin
      errors++;
      $display("FAIL square_hold: got %h expected %h", obs(), ev(0,0,0,16'h0000));
    end
  endtask

  task automatic test_glitch_free();
    logic [18:0] exp_v [8];
    exp_v = '{ev(1,0,0,16'h4000), ev(1,0,1,16'h8000), ev(1,0,1,16'hC000), ev(1,1,0,16'h0000),
              ev(1,0,0,16'h2000), ev(1,0,0,16'h4000), ev(1,0,0,16'h6000), ev(1,0,1,16'h8000)};
    start(32'h4000_0000, 16'h8000);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) increment = 32'h2000_0000;
      step(1'b1, 1'b0, 1'b1);
      checks++;
      $display("glitch[%0d]: obs=%h", i, obs());
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("FAIL glitch[%0d]: got %h expected %h", i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_restart_tick();
    logic [18:0] exp_v [5];
    logic        t_v [5];
    logic        r_v [5];
    exp_v = '{ev(1,0,0,16'h4000), ev(1,0,1,16'h8000), ev(1,0,0,16'h0000),
              ev(1,0,0,16'h4000), ev(1,0,0,16'h0000)};
    t_v = '{1, 1, 1, 1, 0};
    r_v = '{0, 0, 1, 0, 1};
    start(32'h4000_0000, 16'h8000);
    for (int i = 0; i < 5; i++) begin
      step(t_v[i], r_v[i], 1'b1);
      checks++;
      $display("restart[%0d]: tick=%0b restart=%0b obs=%h", i, t_v[i], r_v[i], obs());
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("FAIL restart[%0d]: got %h expected %h", i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_duty_extremes();
    logic [18:0] exp_v [9];
    logic        r_v [9];
    exp_v = '{ev(1,0,1,16'h0000), ev(1,0,1,16'h4000), ev(1,0,1,16'h8000),
              ev(1,0,1,16'hC000), ev(1,1,1,16'h0000),
              ev(1,0,0,16'h0000), ev(1,0,1,16'hFFFF), ev(1,1,0,16'hFFFE),
              ev(1,1,0,16'h0000)};
    r_v = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    increment = 32'h4000_0000;
    duty      = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        increment = 32'hFFFF_0000;
        duty      = 16'hFFFF;
      end
      if (i == 7) increment = 32'h0002_0000;
      step(!r_v[i], r_v[i], 1'b1);
      checks++;
      $display("duty[%0d]: obs=%h", i, obs());
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("FAIL duty[%0d]: got %h expected %h", i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_inc_zero();
    increment = 32'h0;
    duty      = 16'h8000;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1'b1, 1'b0, 1'b1);
      checks++;
      $display("inc_zero[%0d]: obs=%h", i, obs());
      if (obs() !== ev(1,0,0,16'h0000)) begin
        errors++;
        $display("FAIL inc_zero[%0d]: got %h expected %h", i, obs(), ev(1,0,0,16'h0000));
      end
    end
  endtask

  task automatic test_gate_off();
    logic [18:0] exp_v [5];
    logic        t_v [5];
    logic        e_v [5];
    exp_v = '{ev(1,0,0,16'h4000), ev(0,0,0,16'h0000), ev(0,0,0,16'h0000),
              ev(0,0,0,16'h0000), ev(1,0,0,16'h1234)};
    t_v = '{1, 1, 1, 0, 1};
    e_v = '{1, 0, 0, 1, 1};
    start(32'h4000_0000, 16'h8000);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) increment = 32'h1234_5678;
      step(t_v[i], 1'b0, e_v[i]);
      checks++;
      $display("gate[%0d]: tick=%0b enable=%0b obs=%h", i, t_v[i], e_v[i], obs());
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("FAIL gate[%0d]: got %h expected %h", i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    start(32'h4000_0000, 16'h8000);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    $display("rst_mid pre: obs=%h", obs());
    if (obs() !== ev(1,0,1,16'h8000)) begin
      errors++;
      $display("FAIL rst_mid_pre: got %h expected %h", obs(), ev(1,0,1,16'h8000));
    end
    sample_tick = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    $display("rst_mid async: obs=%h", obs());
    if (obs() !== 19'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got %h expected %h", obs(), 19'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    checks++;
    $display("rst_mid load: obs=%h", obs());
    if (obs() !== 19'h0) begin
      errors++;
      $display("FAIL rst_mid_load: got %h expected %h", obs(), 19'h0);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    $display("rst_mid tick: obs=%h", obs());
    if (obs() !== ev(1,0,0,16'h4000)) begin
      errors++;
      $display("FAIL rst_mid_tick: got %h expected %h", obs(), ev(1,0,0,16'h4000));
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_glitch_free();
    test_restart_tick();
    test_duty_extremes();
    test_inc_zero();
    test_gate_off();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
